// File: rtl/vc_mem_copy_initiator.sv
// vc_mem_copy_initiator
//   Copy engine that moves cmd_cnt full words from cmd_src to cmd_dst. It
//   issues one VC mem request at a time: a read, then a write of the data
//   that came back. It drives the requester side of a single-port memory.
//
//   Optional feature macro: VC_MEM_COPY_CHECK_EN. When defined, every write
//   is followed by a read-back of the destination word. A mismatch sets the
//   sticky err flag. When undefined, the check states are absent and err is
//   tied to 0.
//
//   Ports
//     clk, reset        clock; asynchronous active-low reset
//     cmd_val/rdy       copy command handshake (rdy only in IDLE)
//     cmd_src/dst/cnt   first source byte address, first destination byte
//                       address, word count
//     memreq_*          VC mem request  {type, addr, len, data}
//     memresp_*         VC mem response {type, len, data}
//     busy              high in every state except IDLE
//     done              one-cycle pulse when a command completes
//     err               sticky read-back mismatch flag
module vc_mem_copy_initiator #(
    parameter  int p_addr_sz = 16,
    parameter  int p_data_sz = 32,
    parameter  int p_cnt_sz  = 8,
    // The VC message sizes are derived from the field widths.
    localparam int LEN_SZ    = $clog2(p_data_sz / 8),
    localparam int REQ_SZ    = 1 + p_addr_sz + LEN_SZ + p_data_sz,
    localparam int RESP_SZ   = 1 + LEN_SZ + p_data_sz
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_val,
    output logic                 cmd_rdy,
    input  logic [p_addr_sz-1:0] cmd_src,
    input  logic [p_addr_sz-1:0] cmd_dst,
    input  logic [p_cnt_sz-1:0]  cmd_cnt,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    output logic [REQ_SZ-1:0]    memreq_msg,
    input  logic                 memresp_val,
    output logic                 memresp_rdy,
    input  logic [RESP_SZ-1:0]   memresp_msg,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic                 MSG_READ   = 1'b0;
    localparam logic                 MSG_WRITE  = 1'b1;
    localparam logic [p_addr_sz-1:0] WORD_BYTES = p_addr_sz'(p_data_sz / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
`ifdef VC_MEM_COPY_CHECK_EN
        CK_REQ,
        CK_WAIT,
`endif
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [p_addr_sz-1:0]   src_q, src_d;
    logic [p_addr_sz-1:0]   dst_q, dst_d;
    logic [p_cnt_sz-1:0]    cnt_q, cnt_d;    // words still to copy
    logic [p_data_sz-1:0]   buf_q, buf_d;
    logic                   advance;

    logic [p_data_sz-1:0]   resp_data;
    logic                   unused_resp_bits;

    assign resp_data = memresp_msg[p_data_sz-1:0];
    // The len field is never used. The type field is only used by the check.
    assign unused_resp_bits = ^memresp_msg[RESP_SZ-1:p_data_sz];

`ifdef VC_MEM_COPY_CHECK_EN
    logic err_q, err_d;
    logic resp_type;
    assign resp_type = memresp_msg[RESP_SZ-1];
    assign err       = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
`ifdef VC_MEM_COPY_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
`ifdef VC_MEM_COPY_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        advance = 1'b0;
`ifdef VC_MEM_COPY_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Responses that arrive here are stale and are dropped.
                if (cmd_val) begin
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    cnt_d   = cmd_cnt;
`ifdef VC_MEM_COPY_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = (cmd_cnt == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ:  if (memreq_rdy) state_d = RD_WAIT;
            RD_WAIT: begin
                if (memresp_val) begin
                    buf_d   = resp_data;
                    state_d = WR_REQ;
                end
            end
            WR_REQ:  if (memreq_rdy) state_d = WR_WAIT;
            WR_WAIT: begin
                if (memresp_val) begin
`ifdef VC_MEM_COPY_CHECK_EN
                    state_d = CK_REQ;
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef VC_MEM_COPY_CHECK_EN
            CK_REQ:  if (memreq_rdy) state_d = CK_WAIT;
            CK_WAIT: begin
                if (memresp_val) begin
                    if (resp_data != buf_q || resp_type != MSG_READ) err_d = 1'b1;
                    advance = 1'b1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Step to the next word. Pointer addition wraps modulo 2^p_addr_sz.
        if (advance) begin
            src_d   = src_q + WORD_BYTES;
            dst_d   = dst_q + WORD_BYTES;
            cnt_d   = cnt_q - p_cnt_sz'(1);
            state_d = (cnt_q == p_cnt_sz'(1)) ? DONE : RD_REQ;
        end
    end

    // All outputs decode from registered state only. No input feeds an output.
    always_comb begin
        cmd_rdy     = (state_q == IDLE);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        memreq_val  = (state_q == RD_REQ) || (state_q == WR_REQ)
`ifdef VC_MEM_COPY_CHECK_EN
                   || (state_q == CK_REQ)
`endif
                   ;
        memresp_rdy = (state_q == IDLE) || (state_q == RD_WAIT) || (state_q == WR_WAIT)
`ifdef VC_MEM_COPY_CHECK_EN
                   || (state_q == CK_WAIT)
`endif
                   ;
        memreq_msg  = '0;
        if (state_q == WR_REQ) begin
            memreq_msg = {MSG_WRITE, dst_q, {LEN_SZ{1'b0}}, buf_q};
        end else if (state_q == RD_REQ) begin
            memreq_msg = {MSG_READ, src_q, {LEN_SZ{1'b0}}, {p_data_sz{1'b0}}};
        end else begin
            // The check read-back targets the destination word.
            memreq_msg = {MSG_READ, dst_q, {LEN_SZ{1'b0}}, {p_data_sz{1'b0}}};
        end
    end

endmodule

// File: tb/tb_vc_mem_copy_initiator.sv
`timescale 1ns/1ps
module tb_vc_mem_copy_initiator;

    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int CW      = 8;
    localparam int REQ_SZ  = 1 + AW + 2 + DW;
    localparam int RESP_SZ = 1 + 2 + DW;
`ifdef VC_MEM_COPY_CHECK_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int WC    = CK ? 6 : 4;   // cycles per word, zero-delay memory
    localparam int LIMIT = 6000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_val = 1'b0;
    logic               cmd_rdy;
    logic [AW-1:0]      cmd_src = '0;
    logic [AW-1:0]      cmd_dst = '0;
    logic [CW-1:0]      cmd_cnt = '0;
    logic               memreq_val;
    logic               memreq_rdy = 1'b0;
    logic [REQ_SZ-1:0]  memreq_msg;
    logic               memresp_val = 1'b0;
    logic               memresp_rdy;
    logic [RESP_SZ-1:0] memresp_msg = '0;
    logic               busy, done, err;

    vc_mem_copy_initiator #(.p_addr_sz(AW), .p_data_sz(DW), .p_cnt_sz(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_cnt(cmd_cnt),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic t; logic [DW-1:0] d; } resp_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] mem  [0:16383];   // memory seen by the DUT
    logic [DW-1:0] refm [0:16383];   // expected image
    resp_t         resp_q[$];
    logic [AW-1:0] rd_addrs[$];
    int            stall = 0;
    int            fixed_delay = -1;
    bit            corrupt_en = 0;
    logic [AW-1:0] corrupt_addr = '0;
    int            writes_fired = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rand_delay();
        if (fixed_delay >= 0) return fixed_delay;
        if (stall == 0) return 0;
        return int'($urandom_range(0, stall));
    endfunction

    // Memory model. All DUT outputs depend only on DUT state, so values seen
    // just after a negedge tell which handshakes happen at the next posedge.
    initial begin : memproc
        int            resp_wait;
        bit            prev_stall;
        logic [REQ_SZ-1:0] prev_msg;
        logic [AW-1:0] addr;
        logic [DW-1:0] rd;
        resp_wait  = 0;
        prev_stall = 0;
        prev_msg   = '0;
        forever begin
            @(negedge clk); #1;
            if (reset && prev_stall && memreq_val) chk("req_msg_stable", 64'(memreq_msg), 64'(prev_msg));
            if (resp_q.size() > 0 && resp_wait == 0) begin
                memresp_val = 1'b1;
                memresp_msg = {resp_q[0].t, 2'b00, resp_q[0].d};
            end else begin
                memresp_val = 1'b0;
                if (resp_q.size() > 0) resp_wait--;
            end
            if (memresp_val && memresp_rdy) begin
                void'(resp_q.pop_front());
                resp_wait = rand_delay();
            end
            memreq_rdy = (stall == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (reset && memreq_val && memreq_rdy) begin
                chk("one_outstanding", 64'(resp_q.size()), 64'd0);
                addr = memreq_msg[REQ_SZ-2 -: AW];
                if (resp_q.size() == 0) resp_wait = rand_delay();
                if (memreq_msg[REQ_SZ-1]) begin
                    mem[addr[15:2]] = memreq_msg[DW-1:0];
                    writes_fired++;
                    resp_q.push_back(resp_t'{t: 1'b1, d: '0});
                end else begin
                    rd = mem[addr[15:2]];
                    if (corrupt_en && addr == corrupt_addr) rd = rd ^ 32'h1;
                    rd_addrs.push_back(addr);
                    resp_q.push_back(resp_t'{t: 1'b0, d: rd});
                end
            end
            prev_stall = reset && memreq_val && !memreq_rdy;
            prev_msg   = memreq_msg;
        end
    end

    // Reference model: a sequential word copy with 16-bit address wrap.
    task automatic ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int c);
        logic [AW-1:0] sa, da;
        for (int i = 0; i < c; i++) begin
            sa = s + AW'(4 * i);
            da = d + AW'(4 * i);
            refm[da[15:2]] = refm[sa[15:2]];
        end
    endtask

    task automatic chk_image(input string name);
        int diffs = 0;
        for (int i = 0; i < 16384; i++) if (mem[i] !== refm[i]) diffs++;
        chk(name, 64'(diffs), 64'd0);
    endtask

    // Issues one command and follows it to its done pulse.
    task automatic run_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [CW-1:0] c,
                           output int lat, output int busyc, output bit sawreq,
                           output logic err1, output logic errd);
        lat = -1; busyc = 0; sawreq = 0; err1 = 1'bx; errd = 1'bx;
        @(negedge clk);
        chk("cmd_rdy_idle", 64'(cmd_rdy), 64'd1);
        cmd_val = 1'b1; cmd_src = s; cmd_dst = d; cmd_cnt = c;
        @(negedge clk);
        cmd_val = 1'b0;
        err1 = err;
        for (int n = 1; n <= LIMIT; n++) begin
            if (n > 1) @(negedge clk);
            if (busy) busyc++;
            if (memreq_val) sawreq = 1;
            if (done) begin lat = n; errd = err; break; end
        end
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", LIMIT);
        end else begin
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("cmd_rdy_after_done", 64'(cmd_rdy), 64'd1);
            chk("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [CW-1:0] cnt;
        int            exp_lat;   // zero-delay memory; busy cycles equal this
        bit            exp_req;
    } vec_t;

    initial begin : main
        vec_t     vt[6];
        int       lat, busyc;
        bit       sawreq;
        logic     err1, errd;
        logic [AW-1:0] s, d;
        logic [CW-1:0] c;
        int       w0;

        vt[0] = '{16'h0000, 16'h0100, 8'd2,   2 * WC + 1,   1'b1};
        vt[1] = '{16'h0010, 16'h0020, 8'd0,   1,            1'b0};
        vt[2] = '{16'hfffc, 16'h0200, 8'd2,   2 * WC + 1,   1'b1};
        vt[3] = '{16'h0400, 16'h0800, 8'd5,   5 * WC + 1,   1'b1};
        vt[4] = '{16'h1000, 16'h1004, 8'd3,   3 * WC + 1,   1'b1};
        vt[5] = '{16'h2000, 16'h3000, 8'd255, 255 * WC + 1, 1'b1};

        for (int i = 0; i < 16384; i++) begin
            mem[i]  = $urandom;
            refm[i] = mem[i];
        end
        mem[0] = 32'h0a0b0c0d; refm[0] = 32'h0a0b0c0d;
        mem[1] = 32'h0e0f0102; refm[1] = 32'h0e0f0102;

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_memreq_val", 64'(memreq_val), 64'd0);
        chk("rst_memresp_rdy", 64'(memresp_rdy), 64'd1);
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table with a zero-delay memory.
        for (int i = 0; i < 6; i++) begin
            rd_addrs.delete();
            run_cmd(vt[i].src, vt[i].dst, vt[i].cnt, lat, busyc, sawreq, err1, errd);
            ref_copy(vt[i].src, vt[i].dst, int'(vt[i].cnt));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("v%0d_busy_cycles", i), 64'(busyc), 64'(vt[i].exp_lat));
            chk($sformatf("v%0d_any_req", i), 64'(sawreq), 64'(vt[i].exp_req));
            chk($sformatf("v%0d_err", i), 64'(errd), 64'd0);
            chk_image($sformatf("v%0d_image", i));
            if (i == 0) begin
                chk("v0_dst_word0", 64'(mem[16'h0100 >> 2]), 64'h0a0b0c0d);
                chk("v0_dst_word1", 64'(mem[16'h0104 >> 2]), 64'h0e0f0102);
            end
            if (i == 2) begin
                chk("v2_rd_count", 64'(rd_addrs.size()), 64'(2 * (1 + CK)));
                if (rd_addrs.size() > (CK ? 2 : 1))
                    chk("v2_wrap_addr", 64'(rd_addrs[CK ? 2 : 1]), 64'h0000);
            end
        end

        // Randomized stalls checked against the reference copy.
        stall = 10;
        for (int k = 0; k < 6; k++) begin
            s = {AW'($urandom_range(0, 16383))} << 2;
            d = {AW'($urandom_range(0, 16383))} << 2;
            c = CW'($urandom_range(1, 12));
            run_cmd(s, d, c, lat, busyc, sawreq, err1, errd);
            ref_copy(s, d, int'(c));
            chk($sformatf("rnd%0d_image", k), 64'(mem[d[15:2]] === refm[d[15:2]]), 64'd1);
            chk_image($sformatf("rnd%0d_full_image", k));
        end
        stall = 0;

        // Reset during the WR_WAIT of the first of four words.
        fixed_delay = 4;
        w0 = writes_fired;
        @(negedge clk);
        cmd_val = 1'b1; cmd_src = 16'h4000; cmd_dst = 16'h5000; cmd_cnt = 8'd4;
        @(negedge clk);
        cmd_val = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (writes_fired > w0) break;
        end
        chk("mid_wr_wait_state", 64'(memresp_rdy && busy && !memreq_val), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_memreq_val", 64'(memreq_val), 64'd0);
        chk("mid_rst_memresp_rdy", 64'(memresp_rdy), 64'd1);
        chk("mid_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        ref_copy(16'h4000, 16'h5000, 1);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 20 && resp_q.size() > 0; n++) @(negedge clk);
        chk("stale_drained", 64'(resp_q.size()), 64'd0);
        fixed_delay = -1;
        run_cmd(16'h6000, 16'h7000, 8'd1, lat, busyc, sawreq, err1, errd);
        ref_copy(16'h6000, 16'h7000, 1);
        chk("after_rst_latency", 64'(lat), 64'(WC + 1));
        chk_image("after_rst_image");

`ifdef VC_MEM_COPY_CHECK_EN
        // A corrupted read-back of 0x0104 sets err, but the copy still finishes.
        corrupt_en = 1; corrupt_addr = 16'h0104;
        run_cmd(16'h0000, 16'h0100, 8'd2, lat, busyc, sawreq, err1, errd);
        ref_copy(16'h0000, 16'h0100, 2);
        chk("ck_err_set", 64'(errd), 64'd1);
        chk("ck_latency", 64'(lat), 64'(2 * WC + 1));
        chk("ck_err_sticky", 64'(err), 64'd1);
        corrupt_en = 0;
        run_cmd(16'h0008, 16'h0300, 8'd1, lat, busyc, sawreq, err1, errd);
        ref_copy(16'h0008, 16'h0300, 1);
        chk("ck_err_cleared", 64'(err1), 64'd0);
        chk("ck_err_final", 64'(errd), 64'd0);
        chk_image("ck_image");
`else
        chk("nock_err_zero", 64'(err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_mem_copy_initiator.md
# vc_mem_copy_initiator

Memory-request initiator that copies a block of full words from a source address range to a destination address range. It issues read/write messages on the standard VC mem request/response val/rdy interface and sits on the requester side of a single-port test memory. This gives the team a self-driving traffic generator and copy engine in place of a scripted test source/sink pair.

## Interface
- p_addr_sz, 16, width of the mem request address field in bits
- p_data_sz, 32, width of the mem request/response data field in bits
- p_cnt_sz, 8, width of the word-count field of a copy command
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_val  in  1  copy command valid
- cmd_rdy  out  1  engine can accept a command (high only in IDLE)
- cmd_src  in  p_addr_sz  byte address of the first source word
- cmd_dst  in  p_addr_sz  byte address of the first destination word
- cmd_cnt  in  p_cnt_sz  number of words to copy
- memreq_val  out  1  request valid
- memreq_rdy  in  1  memory accepts the request
- memreq_msg  out  VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)  request message
- memresp_val  in  1  response valid
- memresp_rdy  out  1  engine accepts the response
- memresp_msg  in  VC_MEM_RESP_MSG_SZ(p_data_sz)  response message
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  sticky check-failure flag (tied 0 without VC_MEM_COPY_CHECK_EN)

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, CK_REQ, CK_WAIT, DONE. CK_* exist only with the macro.
- IDLE: cmd_rdy=1. On cmd_val&cmd_rdy, latch src/dst/cnt, clear err, clear word index.
  - cnt==0: go to DONE.
  - Otherwise: go to RD_REQ.
- RD_REQ: memreq_val=1, msg type=READ, addr=src_ptr, len=0, data=0. On fire, go to RD_WAIT.
- RD_WAIT: memresp_rdy=1. On memresp_val, capture the response data field into data_buf, go to WR_REQ.
- WR_REQ: memreq_val=1, type=WRITE, addr=dst_ptr, len=0, data=data_buf. On fire, go to WR_WAIT.
- WR_WAIT: memresp_rdy=1. On memresp_val, advance.
  - With the check feature: go to CK_REQ.
  - Without it: src_ptr and dst_ptr each advance by p_data_sz/8; remaining count decrements; go to RD_REQ, or to DONE if this was the last word.
- DONE: done=1 for exactly one cycle, then IDLE.
- Pointer arithmetic is modulo 2^p_addr_sz; addresses wrap silently.
- The response type field is ignored except under the check feature.
- memresp_rdy is also 1 in IDLE. Stale responses (e.g. after reset mid-transaction) are accepted and discarded there.
- At most one request is outstanding at any time.

## Timing
- Reset values: memreq_val=0, memresp_rdy=1, cmd_rdy=1, busy=0, done=0, err=0. State=IDLE, pointers, count and data_buf all 0.
- Reset asserted mid-copy: all outputs take their reset values immediately (async). The command is abandoned.
- memreq_msg is driven from registers only. memreq_val does not depend combinationally on memreq_rdy.
- A request fires in the cycle memreq_val&memreq_rdy. The FSM is in the next state on the following edge.
- With an always-ready memory that responds one cycle after a request, each word takes 4 cycles (6 with check).
- done rises 1 cycle after the last WR_WAIT (or CK_WAIT) handshake.
- For cnt==0, done pulses 1 cycle after command acceptance.
- Back-to-back commands: cmd_rdy returns 1 in the cycle after DONE.

## Configuration
- VC_MEM_COPY_CHECK_EN defined:
  - After each write's response, CK_REQ reads dst_ptr back.
  - In CK_WAIT, err is set if the response data ≠ data_buf or the response type ≠ READ.
  - Copying continues after a mismatch; err stays set until the next command is accepted.
- VC_MEM_COPY_CHECK_EN undefined: CK states are absent and err is constant 0.

## Test plan
- Preload mem 0x0000=0x0a0b0c0d, 0x0004=0x0e0f0102. Command src=0x0000, dst=0x0100, cnt=2 -> mem 0x0100=0x0a0b0c0d, 0x0104=0x0e0f0102. done pulses once; zero-delay memory finishes in 9 cycles after acceptance (4 without check ×2 +1).
- cnt=0 -> no memreq_val ever asserted; done pulses 1 cycle after acceptance; busy high exactly 1 cycle.
- src=0xfffc, dst=0x0200, cnt=2 with 16-bit address -> second read targets 0x0000 (wrap).
- Random memreq_rdy/memresp_val stalls of 0–10 cycles -> identical final memory image; at most one outstanding request; memreq_msg stable while val&!rdy.
- Reset pulse during WR_WAIT of word 1 of 4 -> outputs return to reset values immediately; a late response is drained in IDLE; a new command (cnt=1) completes correctly.
- With VC_MEM_COPY_CHECK_EN: a memory model that corrupts the readback of dst 0x0104 -> err=1 after that CK_WAIT, done still pulses, and err clears on the next accepted command.
